// File: rtl/Parameter_Definitions.sv
// Shared constants and types for the sequential shift-and-add multiplier datapath.
package Parameter_Definitions;

    localparam int NBits = 16;
    localparam int CNT_W = $clog2(NBits);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate of the unsigned accumulator.
// A zero input negates to zero, because the +1 carry ripples out of the word.
module mult_sign_fix
    import Parameter_Definitions::*;
(
    input  logic [2*NBits-1:0] value_i,
    input  logic               negate_i,
    output logic [2*NBits-1:0] result_o
);

    localparam logic [2*NBits-1:0] ONE = {{(2*NBits-1){1'b0}}, 1'b1};

    assign result_o = negate_i ? (~value_i + ONE) : value_i;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock,
// followed by a sign-restore step. start/busy/done handshake.
module seq_shift_add_multiplier
    import Parameter_Definitions::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NBits-1:0]   multiplicand_mag,
    input  logic [NBits-1:0]   multiplier_mag,
    input  logic               product_neg,
    output logic               busy,
    output logic               done,
    output logic [2*NBits-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBits - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mult_state_e        state_q, state_d;
    logic [NBits-1:0]   mcand_q, mcand_d;
    logic [NBits-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*NBits-1:0] acc_q, acc_d;
    logic [2*NBits-1:0] product_q, product_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2*NBits-1:0] addend;
    logic [2*NBits-1:0] signed_acc;

    mult_sign_fix u_sign_fix (
        .value_i  (acc_q),
        .negate_i (neg_q),
        .result_o (signed_acc)
    );

    // Multiplicand weighted by the bit position currently at the multiplier LSB.
    assign addend = {{NBits{1'b0}}, mcand_q} << count_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        acc_d     = acc_q;
        product_d = product_q;
        neg_d     = neg_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = multiplicand_mag;
                    mplier_d = multiplier_mag;
                    neg_d    = product_neg;
                    acc_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_ONE;
                busy_d   = 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                product_d = signed_acc;
                done_d    = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed corner cases plus
// randomized operands checked against an arithmetic reference model.
module tb_seq_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        neg;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks;
    int failures;

    seq_shift_add_multiplier dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .multiplicand_mag (mcand),
        .multiplier_mag   (mplier),
        .product_neg      (neg),
        .busy             (busy),
        .done             (done),
        .product          (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed product of two magnitudes, truncated to the 32-bit result word.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic n);
        longint m;
        m = longint'(a) * longint'(b);
        if (n) m = -m;
        return m[31:0];
    endfunction

    // Runs one operation starting at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic n,
                          input bit pulse_again,
                          output logic [31:0] p, output int lat, output logic busy_seen,
                          output bit stable, output logic busy_at_done, output logic extra_done);
        logic [31:0] prev;
        prev   = product;
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        neg    = n;
        @(negedge clk);
        start     = 1'b0;
        mcand     = 16'($urandom);
        mplier    = 16'($urandom);
        neg       = 1'($urandom);
        lat       = 0;
        busy_seen = busy;
        stable    = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (product !== prev) stable = 1'b0;
            if (pulse_again && lat == 5) begin
                start  = 1'b1;
                mcand  = 16'd2;
                mplier = 16'd2;
                neg    = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start        = 1'b0;
        p            = product;
        busy_at_done = busy;
        @(negedge clk);
        extra_done = done;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        start  = 1'b0;
        mcand  = 16'h0;
        mplier = 16'h0;
        neg    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (product !== 32'h0) begin
            failures++;
            $display("FAIL reset_product got=%h exp=%h", product, 32'h0);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, product} !== 34'h0) begin
                failures++;
                $display("FAIL idle_hold cycle=%0d got busy=%b done=%b product=%h exp all 0",
                         i, busy, done, product);
            end
        end
    endtask

    task automatic test_op(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic n, input bit pulse_again);
        logic [31:0] p;
        logic [31:0] exp;
        int          lat;
        logic        busy_seen;
        bit          stable;
        logic        busy_at_done;
        logic        extra_done;
        exp = ref_mul(a, b, n);
        run_op(a, b, n, pulse_again, p, lat, busy_seen, stable, busy_at_done, extra_done);
        checks++;
        if (p !== exp) begin
            failures++;
            $display("FAIL %s_product a=%h b=%h neg=%b got=%h exp=%h", name, a, b, n, p, exp);
        end
        checks++;
        if (lat != 17) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=17", name, lat);
        end
        checks++;
        if (busy_seen !== 1'b1 || busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy got first=%b at_done=%b exp 1 0", name, busy_seen, busy_at_done);
        end
        checks++;
        if (extra_done !== 1'b0 || !stable) begin
            failures++;
            $display("FAIL %s_pulse got extra_done=%b product_stable=%b exp 0 1",
                     name, extra_done, stable);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        n;
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            n = 1'($urandom);
            if (i % 5 == 0) a = 16'h8000;
            if (i % 7 == 0) b = 16'h0;
            test_op("random", a, b, n, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        start  = 1'b1;
        mcand  = 16'h1234;
        mplier = 16'h00FF;
        neg    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_before got=%b exp=1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got busy=%b done=%b product=%h exp 0 0 00000000",
                     busy, done, product);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_op("after_reset", 16'd4, 16'd4, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_op("basic", 16'd3, 16'd5, 1'b0, 1'b0);
        test_op("neg", 16'd7, 16'd9, 1'b1, 1'b0);
        test_op("neg_zero", 16'd0, 16'h1234, 1'b1, 1'b0);
        test_op("min_mag", 16'h8000, 16'h8000, 1'b0, 1'b0);
        test_op("max_mag", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        test_op("max_mag_neg", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        test_op("ignored_start", 16'd3, 16'd5, 1'b0, 1'b1);
        test_op("back_to_back_a", 16'd11, 16'd13, 1'b1, 1'b0);
        test_op("back_to_back_b", 16'd17, 16'd19, 1'b0, 1'b0);
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
